// File: rtl/wt_digit_codec_if.sv
// Load strobe, input value and digit-code outputs of one wt_digit_codec field.
interface wt_digit_codec_if;
    logic       EN;
    logic [6:0] VAL;
    logic [7:0] TENS;
    logic [7:0] ONES;
    logic [7:0] TENS_ASC;
    logic [7:0] ONES_ASC;
    logic [7:0] TENS_SEG;
    logic [7:0] ONES_SEG;
    logic       OVR;
    logic       VALID;

    modport master (
        output EN, VAL,
        input  TENS, ONES, TENS_ASC, ONES_ASC, TENS_SEG, ONES_SEG, OVR, VALID
    );

    modport slave (
        input  EN, VAL,
        output TENS, ONES, TENS_ASC, ONES_ASC, TENS_SEG, ONES_SEG, OVR, VALID
    );
endinterface

// File: rtl/wt_digit_codec.sv
// Registered binary (0..99, clamped above) to tens/ones digit converter producing
// binary, ASCII and 7-segment codes for one clock/calendar display field.
module wt_digit_codec #(
    parameter bit LEADING_BLANK  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    wt_digit_codec_if.slave   bus
);

    localparam logic [7:0] SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'h3F;
            4'd1:    pat = 8'h06;
            4'd2:    pat = 8'h5B;
            4'd3:    pat = 8'h4F;
            4'd4:    pat = 8'h66;
            4'd5:    pat = 8'h6D;
            4'd6:    pat = 8'h7D;
            4'd7:    pat = 8'h07;
            4'd8:    pat = 8'h7F;
            4'd9:    pat = 8'h6F;
            default: pat = 8'h00;
        endcase
        return pat ^ SEG_MASK;
    endfunction

    logic [6:0] val_clamped_s;
    logic [6:0] rem_s;
    logic [3:0] tens_s;
    logic       blank_s;
    logic       ovr_s;

    logic [7:0] tens_d, ones_d, tens_asc_d, ones_asc_d, tens_seg_d, ones_seg_d;
    logic [7:0] tens_q, ones_q, tens_asc_q, ones_asc_q, tens_seg_q, ones_seg_q;
    logic       ovr_d, valid_d;
    logic       ovr_q, valid_q;

    // Clamp and split into digits; the subtract chain is fully unrolled (single cycle).
    always_comb begin
        ovr_s         = (bus.VAL > 7'd99);
        val_clamped_s = ovr_s ? 7'd99 : bus.VAL;
        rem_s         = val_clamped_s;
        tens_s        = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (rem_s >= 7'd10) begin
                rem_s  = rem_s - 7'd10;
                tens_s = tens_s + 4'd1;
            end else begin
                rem_s  = rem_s;
                tens_s = tens_s;
            end
        end
        blank_s = LEADING_BLANK && (tens_s == 4'd0);
    end

    // Next-state: load all codes on EN, otherwise hold; VALID pulses for one cycle.
    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        tens_asc_d = tens_asc_q;
        ones_asc_d = ones_asc_q;
        tens_seg_d = tens_seg_q;
        ones_seg_d = ones_seg_q;
        ovr_d      = ovr_q;
        valid_d    = 1'b0;
        if (bus.EN) begin
            tens_d     = {4'd0, tens_s};
            ones_d     = {1'b0, rem_s};
            tens_asc_d = blank_s ? 8'h20 : (8'h30 + {4'd0, tens_s});
            ones_asc_d = 8'h30 + {1'b0, rem_s};
            tens_seg_d = blank_s ? SEG_MASK : seg_encode(tens_s);
            ones_seg_d = seg_encode(rem_s[3:0]);
            ovr_d      = ovr_s;
            valid_d    = 1'b1;
        end else begin
            valid_d    = 1'b0;
        end
    end

    // Output registers; reset shows an unblanked "00".
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tens_q     <= 8'd0;
            ones_q     <= 8'd0;
            tens_asc_q <= 8'h30;
            ones_asc_q <= 8'h30;
            tens_seg_q <= 8'h3F ^ SEG_MASK;
            ones_seg_q <= 8'h3F ^ SEG_MASK;
            ovr_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tens_asc_q <= tens_asc_d;
            ones_asc_q <= ones_asc_d;
            tens_seg_q <= tens_seg_d;
            ones_seg_q <= ones_seg_d;
            ovr_q      <= ovr_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.TENS     = tens_q;
    assign bus.ONES     = ones_q;
    assign bus.TENS_ASC = tens_asc_q;
    assign bus.ONES_ASC = ones_asc_q;
    assign bus.TENS_SEG = tens_seg_q;
    assign bus.ONES_SEG = ones_seg_q;
    assign bus.OVR      = ovr_q;
    assign bus.VALID    = valid_q;

endmodule

// File: tb/tb_wt_digit_codec.sv
// Bench for wt_digit_codec: directed vector table, reset/blanking sequences and
// random loads checked against an arithmetic model on three parameterisations.
module tb_wt_digit_codec;

    typedef struct packed {
        logic [7:0] tens;
        logic [7:0] ones;
        logic [7:0] tasc;
        logic [7:0] oasc;
        logic [7:0] tseg;
        logic [7:0] oseg;
        logic       ovr;
    } obs_t;

    typedef struct {
        logic       en;
        logic [6:0] val;
        obs_t       exp;
        logic       valid;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] val;

    int n_cmp;
    int n_err;

    int  last_val;
    bit  loaded;
    bit  exp_valid;

    logic [7:0] seg_tab [10];
    vec_t       vecs [$];

    wt_digit_codec_if if_a ();
    wt_digit_codec_if if_b ();
    wt_digit_codec_if if_c ();

    assign if_a.EN = en;  assign if_a.VAL = val;
    assign if_b.EN = en;  assign if_b.VAL = val;
    assign if_c.EN = en;  assign if_c.VAL = val;

    wt_digit_codec u_dut (.CLK(clk), .RESET(rst), .bus(if_a));
    wt_digit_codec #(.LEADING_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_blank_al (.CLK(clk), .RESET(rst), .bus(if_b));
    wt_digit_codec #(.LEADING_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_blank_ah (.CLK(clk), .RESET(rst), .bus(if_c));

    obs_t got_a, got_b, got_c;
    assign got_a = {if_a.TENS, if_a.ONES, if_a.TENS_ASC, if_a.ONES_ASC, if_a.TENS_SEG, if_a.ONES_SEG, if_a.OVR};
    assign got_b = {if_b.TENS, if_b.ONES, if_b.TENS_ASC, if_b.ONES_ASC, if_b.TENS_SEG, if_b.ONES_SEG, if_b.OVR};
    assign got_c = {if_c.TENS, if_c.ONES, if_c.TENS_ASC, if_c.ONES_ASC, if_c.TENS_SEG, if_c.ONES_SEG, if_c.OVR};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model(input int v, input bit lb, input bit sal);
        obs_t r;
        int c, t, o;
        logic [7:0] m;
        c = (v > 99) ? 99 : v;
        t = c / 10;
        o = c % 10;
        m = sal ? 8'hFF : 8'h00;
        r.tens = 8'(t);
        r.ones = 8'(o);
        r.tasc = (lb && t == 0) ? 8'h20 : 8'(48 + t);
        r.oasc = 8'(48 + o);
        r.tseg = ((lb && t == 0) ? 8'h00 : seg_tab[t]) ^ m;
        r.oseg = seg_tab[o] ^ m;
        r.ovr  = (v > 99);
        return r;
    endfunction

    function automatic obs_t expect_for(input bit lb, input bit sal);
        return loaded ? model(last_val, lb, sal) : model(0, 1'b0, sal);
    endfunction

    function automatic vec_t mk(input logic e, input logic [6:0] v,
                                input logic [7:0] t, input logic [7:0] o,
                                input logic [7:0] ta, input logic [7:0] oa,
                                input logic [7:0] ts, input logic [7:0] os,
                                input logic ov, input logic vd);
        vec_t r;
        r.en = e; r.val = v; r.valid = vd;
        r.exp = {t, o, ta, oa, ts, os, ov};
        return r;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got t=%h o=%h ta=%h oa=%h ts=%h os=%h ovr=%b required t=%h o=%h ta=%h oa=%h ts=%h os=%h ovr=%b",
                     name, got.tens, got.ones, got.tasc, got.oasc, got.tseg, got.oseg, got.ovr,
                     exp.tens, exp.ones, exp.tasc, exp.oasc, exp.tseg, exp.oseg, exp.ovr);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_obs({tag, "/a"}, got_a, expect_for(1'b0, 1'b1));
        check_obs({tag, "/b"}, got_b, expect_for(1'b1, 1'b1));
        check_obs({tag, "/c"}, got_c, expect_for(1'b1, 1'b0));
        check_val({tag, "/valid"}, {5'd0, if_a.VALID, if_b.VALID, if_c.VALID},
                  exp_valid ? 8'h07 : 8'h00);
    endtask

    // Called at a falling edge: apply inputs, cross one rising edge, return at the next falling edge.
    task automatic step(input logic e, input logic [6:0] v);
        en  = e;
        val = v;
        @(posedge clk);
        @(negedge clk);
        if (e) begin
            last_val = int'(v);
            loaded   = 1'b1;
        end
        exp_valid = e;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        last_val = 0; loaded = 1'b0; exp_valid = 1'b0;
        seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

        vecs.push_back(mk(1'b1, 7'd59,  8'd5, 8'd9, 8'h35, 8'h39, 8'h92, 8'h90, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 7'd23,  8'd2, 8'd3, 8'h32, 8'h33, 8'hA4, 8'hB0, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 7'd7, 8'd2, 8'd3, 8'h32, 8'h33, 8'hA4, 8'hB0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 7'd0,   8'd0, 8'd0, 8'h30, 8'h30, 8'hC0, 8'hC0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 7'd9,   8'd0, 8'd9, 8'h30, 8'h39, 8'hC0, 8'h90, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 7'd10,  8'd1, 8'd0, 8'h31, 8'h30, 8'hF9, 8'hC0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 7'd99,  8'd9, 8'd9, 8'h39, 8'h39, 8'h90, 8'h90, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 7'd100, 8'd9, 8'd9, 8'h39, 8'h39, 8'h90, 8'h90, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 7'd127, 8'd9, 8'd9, 8'h39, 8'h39, 8'h90, 8'h90, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 7'd12,  8'd1, 8'd2, 8'h31, 8'h32, 8'hF9, 8'hA4, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 7'd44,  8'd1, 8'd2, 8'h31, 8'h32, 8'hF9, 8'hA4, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 7'd5,   8'd0, 8'd5, 8'h30, 8'h35, 8'hC0, 8'h92, 1'b0, 1'b1));

        en = 1'b0; val = 7'd0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_model("reset");
        check_obs("reset_const", got_a, {8'd0, 8'd0, 8'h30, 8'h30, 8'hC0, 8'hC0, 1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].val);
            check_obs($sformatf("vec%0d", i), got_a, vecs[i].exp);
            check_val($sformatf("vec%0d_valid", i), {7'd0, if_a.VALID}, {7'd0, vecs[i].valid});
            check_model($sformatf("vec%0d_model", i));
        end

        // Last vector loaded 5: blanked tens on the leading-blank instances.
        check_val("blank_al_tasc", got_b.tasc, 8'h20);
        check_val("blank_al_tseg", got_b.tseg, 8'hFF);
        check_val("blank_al_tens", got_b.tens, 8'h00);
        check_val("blank_al_oseg", got_b.oseg, 8'h92);
        check_val("blank_ah_tseg", got_c.tseg, 8'h00);
        check_val("blank_ah_oseg", got_c.oseg, 8'h6D);

        // Asynchronous reset mid-cycle while holding 57, with a load pending.
        step(1'b1, 7'd57);
        check_model("pre_reset57");
        en = 1'b1; val = 7'd88;
        #2 rst = 1'b1;
        #1;
        loaded = 1'b0; exp_valid = 1'b0;
        check_model("async_reset");
        check_obs("async_reset_const", got_a, {8'd0, 8'd0, 8'h30, 8'h30, 8'hC0, 8'hC0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        check_model("reset_discard");
        step(1'b0, 7'd3);
        check_model("post_reset_hold");

        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, 7'($urandom_range(0, 127)));
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wt_digit_codec.md
Name: wt_digit_codec

Overview:
- Registered converter from a 7-bit binary field value (hour, minute, second, year, month, day; nominal range 0..99) to display digit codes.
- Splits the value into tens and ones digits, then encodes each digit as a binary digit, an LCD ASCII character and a 7-segment pattern.
- Sits between the clock/calendar counters and the LCD/FND display drivers.
- One instance serves one displayed field.

Parameters:
- LEADING_BLANK, 0: when 1, a tens digit of 0 is shown as ASCII space 0x20 and a blank 7-segment pattern.
- SEG_ACTIVE_LOW, 1: when 1, the 7-segment outputs are inverted so that 0 means the segment is lit.

Ports:
- CLK  input  1  system clock; all registers update on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- EN  input  1  load strobe; VAL is sampled on a rising CLK edge while EN=1.
- VAL  input  7  binary value to convert, unsigned.
- TENS  output  8  tens digit in binary, 0..9.
- ONES  output  8  ones digit in binary, 0..9.
- TENS_ASC  output  8  ASCII code of the tens digit.
- ONES_ASC  output  8  ASCII code of the ones digit.
- TENS_SEG  output  8  7-segment pattern of the tens digit, bit order {dp,g,f,e,d,c,b,a}.
- ONES_SEG  output  8  7-segment pattern of the ones digit, same bit order.
- OVR  output  1  high when the last loaded VAL was greater than 99.
- VALID  output  1  one-cycle pulse marking that new output data has been loaded.

Behaviour:
- Reset (asynchronous, active-high):
  - TENS=0, ONES=0.
  - TENS_ASC=ONES_ASC=0x30 ('0').
  - TENS_SEG=ONES_SEG = "0" pattern: 0xC0 with SEG_ACTIVE_LOW=1, 0x3F with SEG_ACTIVE_LOW=0.
  - OVR=0, VALID=0.
  - LEADING_BLANK does not apply at reset.
  - If reset is asserted mid-operation, outputs return to these values immediately; a load pending in that cycle is discarded.
- Load:
  - On a rising CLK edge with EN=1, all digit outputs and OVR update from VAL.
  - Latency is 1 cycle: results are visible after the edge that sampled EN=1.
  - VALID=1 for exactly that following cycle.
- Hold: with EN=0, all digit outputs and OVR hold their values and VALID=0. Back-to-back EN gives one update and one VALID pulse per cycle.
- Split:
  - Tens = VAL / 10 and ones = VAL mod 10, using integer arithmetic.
  - Implemented combinationally, either by compare/subtract or by a constant-divide; no multi-cycle iteration.
- Range handling: if VAL > 99 (100..127), the value is clamped to 99 (tens=9, ones=9) and OVR=1; otherwise OVR=0.
- ASCII encoding:
  - Code = 0x30 + digit, so 0..9 map to 0x30..0x39.
  - Tens digit 0 with LEADING_BLANK=1 gives 0x20.
- 7-segment encoding (active-high, dp always off):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Blank = 0x00.
  - SEG_ACTIVE_LOW=1 inverts all 8 bits, so blank becomes 0xFF.
- Binary outputs: TENS and ONES are zero-extended to 8 bits. They are never blanked by LEADING_BLANK.
- Only the tens digit can be blanked; the ones digit is always shown, so an input of 0 displays as " 0".
- Glitch rule: all outputs come directly from registers, with no combinational path from VAL or EN to any output.

Test Plan:
- Reset: assert RESET mid-cycle while outputs hold 57 -> TENS=0, ONES=0, ASCII 0x30/0x30, SEG 0xC0/0xC0, VALID=0, all immediately with no clock edge.
- Normal load: VAL=59, EN=1 for one cycle -> next cycle TENS=5, ONES=9, TENS_ASC=0x35, ONES_ASC=0x39, TENS_SEG=~0x6D=0x92, ONES_SEG=~0x6F=0x90, VALID=1 for one cycle only, OVR=0.
- Hold: load 23, then change VAL to 7 with EN=0 for 5 cycles -> outputs stay 2/3 and VALID stays 0.
- Boundaries: load 0, 9, 10, 99 on consecutive EN cycles -> digit pairs 0/0, 0/9, 1/0, 9/9 on consecutive cycles, one VALID per load.
- Overflow: VAL=100, then VAL=127 -> TENS=9, ONES=9, OVR=1; a following load of 12 -> 1/2 with OVR=0.
- Leading blank: LEADING_BLANK=1 with VAL=5 -> TENS_ASC=0x20, TENS_SEG=0xFF, TENS=0, ONES_ASC=0x35, ONES_SEG=0x92. With SEG_ACTIVE_LOW=0, TENS_SEG=0x00.
